lcd_spi_responder: RTL

//  Panel-side end of the 4-wire SPI LCD link (SCL/CS/DC/SDA, MSB first, write-only, ST7789 command subset).

---
 rtl/lcd_spi_responder_if.sv | 34 +++
 rtl/lcd_spi_responder.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_spi_responder_if.sv
// -----------------------------------------------------------------------------
// lcd_spi_responder_if
//   Carries the 4-wire SPI LCD link plus the panel reset line. The initiator
//   drives every signal. The panel-side responder only receives them.
//   Signals:
//     lcd_resetn  panel reset, active low
//     lcd_clk     SPI clock, data valid on the rising edge
//     lcd_cs      chip select, active low
//     lcd_rs      0 = command byte, 1 = data/parameter byte
//     lcd_data    serial data, MSB first
// -----------------------------------------------------------------------------
interface lcd_spi_responder_if;
    logic lcd_resetn;
    logic lcd_clk;
    logic lcd_cs;
    logic lcd_rs;
    logic lcd_data;

    modport master (
        output lcd_resetn,
        output lcd_clk,
        output lcd_cs,
        output lcd_rs,
        output lcd_data
    );

    modport slave (
        input lcd_resetn,
        input lcd_clk,
        input lcd_cs,
        input lcd_rs,
        input lcd_data
    );
endinterface

// File: rtl/lcd_spi_responder.sv
// -----------------------------------------------------------------------------
// lcd_spi_responder
//   Panel-side end of a write-only 4-wire SPI LCD link (ST7789 command subset).
//   The link is oversampled in the clk domain, which must run at least 4x
//   lcd_clk. Bytes are framed by lcd_cs and classified by lcd_rs. The module
//   tracks the CASET/RASET window and the RAMWR pointer. It emits one pixel
//   strobe per RGB565 pixel.
//   Ports:
//     clk, reset        system clock; asynchronous active-high reset
//     lcd (slave)       lcd_resetn / lcd_clk / lcd_cs / lcd_rs / lcd_data
//     cmd_valid         1-cycle pulse per command byte; cmd_code holds it
//     pix_valid         1-cycle pulse per pixel, with pix_x / pix_y / pix_data
//     frame_done        pulses with the pixel written at (xe, ye)
//     abort_err         pulses when cs rises mid-byte
//     sleep_out         status bit from 0x11 / 0x10
//     disp_on           status bit from 0x29 / 0x28
//     madctl, colmod    last parameter of 0x36 / 0x3A
// -----------------------------------------------------------------------------
module lcd_spi_responder #(
    parameter int COORD_W = 9,
    parameter int DEF_XE  = 239,
    parameter int DEF_YE  = 319
) (
    input  logic                 clk,
    input  logic                 reset,
    lcd_spi_responder_if.slave   lcd,
    output logic                 cmd_valid,
    output logic [7:0]           cmd_code,
    output logic                 pix_valid,
    output logic [COORD_W-1:0]   pix_x,
    output logic [COORD_W-1:0]   pix_y,
    output logic [15:0]          pix_data,
    output logic                 frame_done,
    output logic                 abort_err,
    output logic                 sleep_out,
    output logic                 disp_on,
    output logic [7:0]           madctl,
    output logic [7:0]           colmod
);

    localparam logic [COORD_W-1:0] XE_RST = COORD_W'(DEF_XE);
    localparam logic [COORD_W-1:0] YE_RST = COORD_W'(DEF_YE);

    typedef enum logic [1:0] {ST_IDLE, ST_PARAM, ST_RAMWR} state_t;

    // Input synchronizers (third clk stage only feeds the edge detector)
    logic clk_s1_q, clk_s2_q, clk_s3_q;
    logic cs_s1_q, cs_s2_q;
    logic rs_s1_q, rs_s2_q;
    logic dat_s1_q, dat_s2_q;
    logic rstn_s1_q, rstn_s2_q;

    // Byte assembly
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shreg_q, shreg_d;
    logic        rs_cap_q, rs_cap_d;
    logic        armed_q, armed_d;
    logic        byte_stb_q, byte_stb_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        byte_rs_q, byte_rs_d;
    logic        abort_q, abort_d;

    // Decoder
    state_t              state_q, state_d;
    logic [2:0]          pidx_q, pidx_d;
    logic                phase_q, phase_d;
    logic [23:0]         par_q, par_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic [7:0]          cmd_code_q, cmd_code_d;
    logic                sleep_q, sleep_d;
    logic                disp_q, disp_d;
    logic [7:0]          madctl_q, madctl_d;
    logic [7:0]          colmod_q, colmod_d;
    logic [COORD_W-1:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [COORD_W-1:0]  ptr_x_q, ptr_x_d, ptr_y_q, ptr_y_d;
    logic [7:0]          px_hi_q, px_hi_d, px_lo_q, px_lo_d;
    logic                pix_pend_q, pix_pend_d;

    // Pixel output
    logic                pix_valid_q, pix_valid_d;
    logic [COORD_W-1:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [15:0]         pix_data_q, pix_data_d;
    logic                frame_done_q, frame_done_d;

    logic        soft_clr;
    logic        sclk_rise;
    logic [15:0] p_start, p_end;

    assign soft_clr  = ~rstn_s2_q;
    assign sclk_rise = clk_s2_q & ~clk_s3_q;
    // Coordinate pair: first three parameter bytes are buffered, fourth is live
    assign p_start   = par_q[23:8];
    assign p_end     = {par_q[7:0], rx_byte_q};

    always_comb begin
        // ---- byte assembly ----
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        rs_cap_d   = rs_cap_q;
        armed_d    = armed_q;
        byte_stb_d = 1'b0;
        rx_byte_d  = rx_byte_q;
        byte_rs_d  = byte_rs_q;
        abort_d    = 1'b0;

        if (cs_s2_q) begin
            // Deselect: any partial byte is discarded. A byte interrupted by
            // a reset never reaches here with a nonzero count, so it cannot
            // raise abort.
            armed_d   = 1'b1;
            abort_d   = (bit_cnt_q != 3'd0);
            bit_cnt_d = 3'd0;
        end else if (sclk_rise && armed_q) begin
            shreg_d = {shreg_q[5:0], dat_s2_q};
            if (bit_cnt_q == 3'd0) begin
                rs_cap_d = rs_s2_q;
            end
            if (bit_cnt_q == 3'd7) begin
                byte_stb_d = 1'b1;
                rx_byte_d  = {shreg_q, dat_s2_q};
                byte_rs_d  = rs_cap_q;
                bit_cnt_d  = 3'd0;
            end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
        end

        // ---- decoder and pixel output ----
        state_d      = state_q;
        pidx_d       = pidx_q;
        phase_d      = phase_q;
        par_d        = par_q;
        cmd_valid_d  = 1'b0;
        cmd_code_d   = cmd_code_q;
        sleep_d      = sleep_q;
        disp_d       = disp_q;
        madctl_d     = madctl_q;
        colmod_d     = colmod_q;
        xs_d         = xs_q;
        xe_d         = xe_q;
        ys_d         = ys_q;
        ye_d         = ye_q;
        ptr_x_d      = ptr_x_q;
        ptr_y_d      = ptr_y_q;
        px_hi_d      = px_hi_q;
        px_lo_d      = px_lo_q;
        pix_pend_d   = 1'b0;
        pix_valid_d  = 1'b0;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_data_d   = pix_data_q;
        frame_done_d = 1'b0;

        // Pending pixel goes out first, so a RAMWR pointer load from a
        // following command (below) takes priority over this advance.
        if (pix_pend_q) begin
            pix_valid_d  = 1'b1;
            pix_x_d      = ptr_x_q;
            pix_y_d      = ptr_y_q;
            pix_data_d   = {px_hi_q, px_lo_q};
            frame_done_d = (ptr_x_q == xe_q) && (ptr_y_q == ye_q);
            if (ptr_x_q == xe_q) begin
                ptr_x_d = xs_q;
                ptr_y_d = (ptr_y_q == ye_q) ? ys_q : ptr_y_q + 1'b1;
            end else begin
                ptr_x_d = ptr_x_q + 1'b1;
            end
        end

        if (byte_stb_q) begin
            if (!byte_rs_q) begin
                cmd_valid_d = 1'b1;
                cmd_code_d  = rx_byte_q;
                pidx_d      = 3'd0;
                phase_d     = 1'b0;
                state_d     = ST_IDLE;
                case (rx_byte_q)
                    8'h2A, 8'h2B, 8'h36, 8'h3A: state_d = ST_PARAM;
                    8'h2C: begin
                        ptr_x_d = xs_q;
                        ptr_y_d = ys_q;
                        state_d = ST_RAMWR;
                    end
                    8'h10: sleep_d = 1'b0;
                    8'h11: sleep_d = 1'b1;
                    8'h28: disp_d  = 1'b0;
                    8'h29: disp_d  = 1'b1;
                    default: ;
                endcase
            end else begin
                case (state_q)
                    ST_PARAM: begin
                        if (pidx_q < 3'd4) begin
                            pidx_d = pidx_q + 3'd1;
                            par_d  = {par_q[15:0], rx_byte_q};
                            case (cmd_code_q)
                                8'h2A: if (pidx_q == 3'd3) begin
                                    xs_d = p_start[COORD_W-1:0];
                                    xe_d = p_end[COORD_W-1:0];
                                end
                                8'h2B: if (pidx_q == 3'd3) begin
                                    ys_d = p_start[COORD_W-1:0];
                                    ye_d = p_end[COORD_W-1:0];
                                end
                                8'h36: if (pidx_q == 3'd0) madctl_d = rx_byte_q;
                                8'h3A: if (pidx_q == 3'd0) colmod_d = rx_byte_q;
                                default: ;
                            endcase
                        end
                    end
                    ST_RAMWR: begin
                        if (!phase_q) begin
                            px_hi_d = rx_byte_q;
                            phase_d = 1'b1;
                        end else begin
                            px_lo_d    = rx_byte_q;
                            pix_pend_d = 1'b1;
                            phase_d    = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end

        // Panel reset from the initiator clears everything except the
        // synchronizers themselves.
        if (soft_clr) begin
            bit_cnt_d    = 3'd0;
            shreg_d      = 7'd0;
            rs_cap_d     = 1'b0;
            armed_d      = 1'b0;
            byte_stb_d   = 1'b0;
            rx_byte_d    = 8'd0;
            byte_rs_d    = 1'b0;
            abort_d      = 1'b0;
            state_d      = ST_IDLE;
            pidx_d       = 3'd0;
            phase_d      = 1'b0;
            par_d        = 24'd0;
            cmd_valid_d  = 1'b0;
            cmd_code_d   = 8'd0;
            sleep_d      = 1'b0;
            disp_d       = 1'b0;
            madctl_d     = 8'd0;
            colmod_d     = 8'd0;
            xs_d         = '0;
            xe_d         = XE_RST;
            ys_d         = '0;
            ye_d         = YE_RST;
            ptr_x_d      = '0;
            ptr_y_d      = '0;
            px_hi_d      = 8'd0;
            px_lo_d      = 8'd0;
            pix_pend_d   = 1'b0;
            pix_valid_d  = 1'b0;
            pix_x_d      = '0;
            pix_y_d      = '0;
            pix_data_d   = 16'd0;
            frame_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // cs sync starts "selected" so bits are ignored until a real
            // deselect arms the receiver.
            clk_s1_q     <= 1'b0;
            clk_s2_q     <= 1'b0;
            clk_s3_q     <= 1'b0;
            cs_s1_q      <= 1'b0;
            cs_s2_q      <= 1'b0;
            rs_s1_q      <= 1'b0;
            rs_s2_q      <= 1'b0;
            dat_s1_q     <= 1'b0;
            dat_s2_q     <= 1'b0;
            rstn_s1_q    <= 1'b0;
            rstn_s2_q    <= 1'b0;
            bit_cnt_q    <= 3'd0;
            shreg_q      <= 7'd0;
            rs_cap_q     <= 1'b0;
            armed_q      <= 1'b0;
            byte_stb_q   <= 1'b0;
            rx_byte_q    <= 8'd0;
            byte_rs_q    <= 1'b0;
            abort_q      <= 1'b0;
            state_q      <= ST_IDLE;
            pidx_q       <= 3'd0;
            phase_q      <= 1'b0;
            par_q        <= 24'd0;
            cmd_valid_q  <= 1'b0;
            cmd_code_q   <= 8'd0;
            sleep_q      <= 1'b0;
            disp_q       <= 1'b0;
            madctl_q     <= 8'd0;
            colmod_q     <= 8'd0;
            xs_q         <= '0;
            xe_q         <= XE_RST;
            ys_q         <= '0;
            ye_q         <= YE_RST;
            ptr_x_q      <= '0;
            ptr_y_q      <= '0;
            px_hi_q      <= 8'd0;
            px_lo_q      <= 8'd0;
            pix_pend_q   <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_data_q   <= 16'd0;
            frame_done_q <= 1'b0;
        end else begin
            clk_s1_q     <= lcd.lcd_clk;
            clk_s2_q     <= clk_s1_q;
            clk_s3_q     <= clk_s2_q;
            cs_s1_q      <= lcd.lcd_cs;
            cs_s2_q      <= cs_s1_q;
            rs_s1_q      <= lcd.lcd_rs;
            rs_s2_q      <= rs_s1_q;
            dat_s1_q     <= lcd.lcd_data;
            dat_s2_q     <= dat_s1_q;
            rstn_s1_q    <= lcd.lcd_resetn;
            rstn_s2_q    <= rstn_s1_q;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            rs_cap_q     <= rs_cap_d;
            armed_q      <= armed_d;
            byte_stb_q   <= byte_stb_d;
            rx_byte_q    <= rx_byte_d;
            byte_rs_q    <= byte_rs_d;
            abort_q      <= abort_d;
            state_q      <= state_d;
            pidx_q       <= pidx_d;
            phase_q      <= phase_d;
            par_q        <= par_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_code_q   <= cmd_code_d;
            sleep_q      <= sleep_d;
            disp_q       <= disp_d;
            madctl_q     <= madctl_d;
            colmod_q     <= colmod_d;
            xs_q         <= xs_d;
            xe_q         <= xe_d;
            ys_q         <= ys_d;
            ye_q         <= ye_d;
            ptr_x_q      <= ptr_x_d;
            ptr_y_q      <= ptr_y_d;
            px_hi_q      <= px_hi_d;
            px_lo_q      <= px_lo_d;
            pix_pend_q   <= pix_pend_d;
            pix_valid_q  <= pix_valid_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_data_q   <= pix_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_code   = cmd_code_q;
    assign pix_valid  = pix_valid_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_data   = pix_data_q;
    assign frame_done = frame_done_q;
    assign abort_err  = abort_q;
    assign sleep_out  = sleep_q;
    assign disp_on    = disp_q;
    assign madctl     = madctl_q;
    assign colmod     = colmod_q;

endmodule
